// File: rtl/imem_loader.sv
// Instruction-memory boot loader: parses A5 / count / big-endian words (/ checksum) frames
// from a byte stream into sequential imem writes. Define IMEM_LOADER_CSUM_EN to enable the checksum byte.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          cnt_hi_reg;
    logic [15:0]         count_reg;
    logic [15:0]         word_idx_reg;
    logic [1:0]          byte_idx_reg;
    logic [23:0]         shift_reg;
    logic                in_ready_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [31:0]         mem_wdata_reg;
    logic                core_run_reg;
    logic                busy_reg;
    logic                error_reg;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]          csum_reg;
`endif

    logic        accept;
    logic [15:0] count_in;
    logic        count_ok;
    logic        last_word_written;

    assign accept   = in_valid & in_ready_reg;
    assign count_in = {cnt_hi_reg, in_data};
    // A frame may fill the whole memory but never wrap past it.
    assign count_ok = (count_in != 16'd0) && (32'(count_in) <= (32'd1 << ADDR_W));
    // word_idx_reg already points past the word being written during the strobe cycle.
    assign last_word_written = mem_we_reg && (word_idx_reg == count_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (accept && in_data == 8'hA5) state_next = CNT_HI;
            CNT_HI:          if (accept) state_next = CNT_LO;
            CNT_LO:          if (accept) state_next = count_ok ? DATA : ERR;
`ifdef IMEM_LOADER_CSUM_EN
            DATA:            if (last_word_written) state_next = CSUM;
            CSUM:            if (accept) state_next = (in_data == csum_reg) ? DONE : ERR;
`else
            DATA:            if (last_word_written) state_next = DONE;
`endif
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_hi_reg    <= '0;
            count_reg     <= '0;
            word_idx_reg  <= '0;
            byte_idx_reg  <= '0;
            shift_reg     <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            core_run_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            core_run_reg <= (state_next == DONE);
            busy_reg     <= (state_next inside {CNT_HI, CNT_LO, DATA, CSUM});
            error_reg    <= (state_next == ERR);
            in_ready_reg <= 1'b1;
            mem_we_reg   <= 1'b0;
            if (accept) begin
                case (state_reg)
                    CNT_HI: cnt_hi_reg <= in_data;
                    CNT_LO: begin
                        count_reg    <= count_in;
                        word_idx_reg <= '0;
                        byte_idx_reg <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_reg     <= '0;
`endif
                    end
                    DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum_reg     <= csum_reg ^ in_data;
`endif
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        shift_reg    <= {shift_reg[15:0], in_data};
                        if (byte_idx_reg == 2'd3) begin
                            // Stall the stream for the strobe cycle so no byte arrives mid-write.
                            mem_we_reg    <= 1'b1;
                            in_ready_reg  <= 1'b0;
                            mem_addr_reg  <= ADDR_W'(word_idx_reg);
                            mem_wdata_reg <= {shift_reg, in_data};
                            word_idx_reg  <= word_idx_reg + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign core_run  = core_run_reg;
    assign busy      = busy_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from random words, and the expected
// write list and final status follow from the frame contents alone.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int MAX_N  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic              busy;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [31:0]        fw[$];
    logic [ADDR_W+31:0] wq[$];
    logic               armed;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_run (core_run),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Write scoreboard capture plus the ready/strobe relation, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) wq.push_back({mem_addr, mem_wdata});
            if (armed) begin
                checks++;
                if (in_ready !== !mem_we) begin
                    errors++;
                    $display("FAIL ready_vs_we: in_ready=%b required %b (mem_we=%b)", in_ready, !mem_we, mem_we);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b required 1 for byte %02h", in_ready, b);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(3) == 0) b = 8'hA5;
        return b;
    endfunction

    task automatic fill_random(input int n);
        fw.delete();
        for (int i = 0; i < n; i++)
            fw.push_back({rand_byte(), rand_byte(), rand_byte(), rand_byte()});
    endtask

    // Sends one frame whose payload is fw; words are only sent when the count is legal.
    task automatic send_frame(input logic [15:0] n, input bit bad_csum, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        wq.delete();
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        if (n != 16'd0 && int'(n) <= MAX_N) begin
            foreach (fw[i]) begin
                for (int k = 3; k >= 0; k--) begin
                    b  = fw[i][k*8 +: 8];
                    cs = cs ^ b;
                    if (gaps && $urandom_range(3) == 0) idle_cycles($urandom_range(1, 3));
                    send_byte(b);
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            send_byte(bad_csum ? (cs ^ 8'h01) : cs);
`else
            if (bad_csum) cs = ~cs;
`endif
        end
        in_valid = 1'b0;
    endtask

    function automatic bit expect_done(input logic [15:0] n, input bit bad_csum);
        bit ok;
        ok = (n != 16'd0) && (int'(n) <= MAX_N);
`ifdef IMEM_LOADER_CSUM_EN
        ok = ok && !bad_csum;
`endif
        return ok;
    endfunction

    task automatic check_frame(input string name, input logic [15:0] n, input bit bad_csum);
        int  exp_words;
        bit  exp_done;
        exp_words = (n != 16'd0 && int'(n) <= MAX_N) ? int'(n) : 0;
        exp_done  = expect_done(n, bad_csum);
        idle_cycles(3);
        checks++;
        if (wq.size() !== exp_words) begin
            errors++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wq.size(), exp_words);
        end
        for (int i = 0; i < exp_words && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== {ADDR_W'(i), fw[i]}) begin
                errors++;
                $display("FAIL %s_write%0d: got addr=%0d data=%08h required addr=%0d data=%08h",
                         name, i, wq[i][ADDR_W+31:32], wq[i][31:0], i, fw[i]);
            end
        end
        checks++;
        if ({core_run, error, busy} !== {exp_done, !exp_done, 1'b0}) begin
            errors++;
            $display("FAIL %s_status: got run/err/busy=%b%b%b required %b%b0",
                     name, core_run, error, busy, exp_done, !exp_done);
        end
        $display("frame %s: N=%0d writes=%0d core_run=%b error=%b", name, n, wq.size(), core_run, error);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d data=%08h run=%b busy=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        $display("reset: outputs cleared, in_ready=%b after release", in_ready);
    endtask

    task automatic test_good_load();
        fw.delete();
        fw.push_back(32'h11223344);
        fw.push_back(32'hAABBCCDD);
        send_frame(16'd2, 1'b0, 1'b0);
        check_frame("good_load", 16'd2, 1'b0);
    endtask

    task automatic test_bad_csum();
        fw.delete();
        fw.push_back(32'h11223344);
        fw.push_back(32'hAABBCCDD);
        send_frame(16'd2, 1'b1, 1'b0);
        check_frame("bad_csum", 16'd2, 1'b1);
    endtask

    task automatic test_count_bound();
        wq.delete();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        in_valid = 1'b0;
        checks++;
        if ({error, busy, core_run} !== 3'b100) begin
            errors++;
            $display("FAIL bound_1025: got err/busy/run=%b%b%b required 100", error, busy, core_run);
        end
        $display("count 1025: error=%b busy=%b", error, busy);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        in_valid = 1'b0;
        checks++;
        if ({error, busy, core_run} !== 3'b100) begin
            errors++;
            $display("FAIL bound_0: got err/busy/run=%b%b%b required 100", error, busy, core_run);
        end
        idle_cycles(3);
        checks++;
        if (wq.size() !== 0) begin
            errors++;
            $display("FAIL bound_no_write: got %0d writes required 0", wq.size());
        end
        $display("count 0: error=%b writes=%0d", error, wq.size());
        fill_random(MAX_N);
        send_frame(16'(MAX_N), 1'b0, 1'b0);
        check_frame("max_count", 16'(MAX_N), 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        wq.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got rdy=%b we=%b addr=%0d data=%08h run=%b busy=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, core_run, busy, error);
        end
        $display("reset mid-frame: busy=%b in_ready=%b", busy, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_random(3);
        send_frame(16'd3, 1'b0, 1'b1);
        check_frame("after_reset", 16'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] n;
        for (int f = 0; f < 3; f++) begin
            n = 16'($urandom_range(2, 6));
            fill_random(int'(n));
            send_frame(n, 1'b0, 1'b0);
            check_frame("back_to_back", n, 1'b0);
        end
        send_byte(8'hA5);
        in_valid = 1'b0;
        checks++;
        if ({core_run, busy} !== 2'b01) begin
            errors++;
            $display("FAIL reload_run_drop: got run/busy=%b%b required 01", core_run, busy);
        end
        $display("reload: core_run=%b busy=%b after A5 in DONE", core_run, busy);
    endtask

    task automatic test_noise();
        logic [7:0] noise [3];
        noise[0] = 8'h00; noise[1] = 8'hFF; noise[2] = 8'h5A;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i]);
            in_valid = 1'b0;
            checks++;
            if ({busy, error, core_run} !== 3'b000) begin
                errors++;
                $display("FAIL noise_%02h: got busy/err/run=%b%b%b required 000", noise[i], busy, error, core_run);
            end
            $display("noise %02h: busy=%b error=%b", noise[i], busy, error);
        end
        fill_random(2);
        send_frame(16'd2, 1'b0, 1'b1);
        check_frame("after_noise", 16'd2, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] n;
        bit          bad;
        for (int f = 0; f < 8; f++) begin
            case ($urandom_range(7))
                0:       n = 16'd0;
                1:       n = 16'($urandom_range(MAX_N + 1, 65535));
                default: n = 16'($urandom_range(1, 6));
            endcase
            bad = ($urandom_range(2) == 0);
            if (n != 16'd0 && int'(n) <= MAX_N) fill_random(int'(n));
            else fw.delete();
            send_frame(n, bad, 1'b1);
            check_frame("random", n, bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
`ifdef IMEM_LOADER_CSUM_EN
        test_bad_csum();
`endif
        test_count_bound();
        test_reset_mid_frame();
        test_back_to_back();
        test_noise();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
